// File: rtl/word_assembler.sv
// Packs NUM_WORDS byte-enabled input words into one output line and holds the
// completed line until the consumer takes it (valid/ready on both sides).
module word_assembler #(
  parameter int WORD_W         = 32,
  parameter int NUM_WORDS      = 4,
  parameter bit CLEAR_ON_START = 1'b0,
  localparam int BE_W          = WORD_W / 8,
  localparam int IDX_W         = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        Load,
  output logic                        In_Ready,
  input  logic [BE_W-1:0]             BYTE_EN,
  input  logic [WORD_W-1:0]           D,
  input  logic                        Flush,
  output logic [WORD_W*NUM_WORDS-1:0] Data_Out,
  output logic [IDX_W-1:0]            Word_Idx,
  output logic                        Line_Valid,
  input  logic                        Line_Ready
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e                      state_q, state_d;
  logic [WORD_W*NUM_WORDS-1:0] data_q, data_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        accept;

  assign Line_Valid = (state_q == FULL);
  assign In_Ready   = !Line_Valid || Line_Ready;
  assign accept     = Load && In_Ready;
  assign Data_Out   = data_q;
  assign Word_Idx   = idx_q;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;

    if (state_q == FULL && Line_Ready) state_d = FILL;

    // Flush only abandons a partial line; a completed line is never dropped.
    if (Flush && state_q == FILL) begin
      idx_d = '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (CLEAR_ON_START && idx_q == '0 && k != 0) data_d[k*WORD_W +: WORD_W] = '0;
        for (int b = 0; b < BE_W; b++) begin
          if (k == int'(idx_q) && BYTE_EN[b]) data_d[k*WORD_W + 8*b +: 8] = D[8*b +: 8];
        end
      end
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        state_d = FULL;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= FILL;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_word_assembler.sv
// Self-checking bench for word_assembler: directed vector table, hand-written
// corner sequences, then random traffic against a byte-array reference model.
module tb_word_assembler;

  localparam int WW = 32;
  localparam int NW = 4;
  localparam int LW = WW * NW;

  logic          CLK = 1'b0;
  logic          RESET_N, Load, Flush, Line_Ready;
  logic [3:0]    BYTE_EN;
  logic [WW-1:0] D;
  logic          In_Ready, Line_Valid;
  logic [LW-1:0] Data_Out;
  logic [1:0]    Word_Idx;

  word_assembler dut (
    .CLK(CLK), .RESET_N(RESET_N), .Load(Load), .In_Ready(In_Ready),
    .BYTE_EN(BYTE_EN), .D(D), .Flush(Flush), .Data_Out(Data_Out),
    .Word_Idx(Word_Idx), .Line_Valid(Line_Valid), .Line_Ready(Line_Ready)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: the line as a plain byte array, a word pointer and a full flag.
  logic [7:0] m_bytes [NW][4];
  int         m_idx;
  bit         m_valid;

  task automatic m_write(input int k, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (be[b]) m_bytes[k][b] = d[8*b +: 8];
  endtask

  task automatic model_step(input bit rst_n, input bit load, input logic [3:0] be,
                            input logic [31:0] d, input bit flush, input bit lr);
    bit acc;
    if (!rst_n) begin
      foreach (m_bytes[k, b]) m_bytes[k][b] = 8'h00;
      m_idx = 0;
      m_valid = 0;
      return;
    end
    acc = load && (!m_valid || lr);
    if (m_valid) begin
      if (lr) begin
        m_valid = 0;
        if (acc) begin
          m_write(0, be, d);
          m_idx = 1;
        end
      end
    end else if (flush) begin
      m_idx = 0;
    end else if (acc) begin
      m_write(m_idx, be, d);
      m_idx++;
      if (m_idx == NW) begin
        m_idx = 0;
        m_valid = 1;
      end
    end
  endtask

  function automatic logic [LW-1:0] m_line();
    logic [LW-1:0] r;
    for (int k = 0; k < NW; k++)
      for (int b = 0; b < 4; b++) r[k*WW + 8*b +: 8] = m_bytes[k][b];
    return r;
  endfunction

  task automatic drive(input bit rst_n, input bit load, input logic [3:0] be,
                       input logic [31:0] d, input bit flush, input bit lr);
    RESET_N = rst_n; Load = load; BYTE_EN = be; D = d; Flush = flush; Line_Ready = lr;
    model_step(rst_n, load, be, d, flush, lr);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data"},  Data_Out,   m_line());
    check({tag, ".idx"},   LW'(Word_Idx), LW'(m_idx));
    check({tag, ".valid"}, LW'(Line_Valid), LW'(m_valid));
    check({tag, ".rdy"},   LW'(In_Ready), LW'(!m_valid || Line_Ready));
  endtask

  typedef struct {
    bit            rst_n;
    bit            load;
    logic [3:0]    be;
    logic [31:0]   d;
    bit            flush;
    bit            lr;
    logic [LW-1:0] exp_data;
    logic [1:0]    exp_idx;
    bit            exp_valid;
    bit            exp_rdy;
  } vec_t;

  function automatic vec_t v(bit rst_n, bit load, logic [3:0] be, logic [31:0] d, bit flush,
                             bit lr, logic [LW-1:0] ed, logic [1:0] ei, bit ev, bit er);
    vec_t r;
    r.rst_n = rst_n; r.load = load; r.be = be; r.d = d; r.flush = flush; r.lr = lr;
    r.exp_data = ed; r.exp_idx = ei; r.exp_valid = ev; r.exp_rdy = er;
    return r;
  endfunction

  vec_t vecs[16];

  initial begin
    RESET_N = 1'b0; Load = 1'b0; Flush = 1'b0; Line_Ready = 1'b0; BYTE_EN = '0; D = '0;
    foreach (m_bytes[k, b]) m_bytes[k][b] = 8'h00;
    m_idx = 0;
    m_valid = 0;

    vecs[0]  = v(0, 1, 4'hF, 32'h99999999, 0, 1, 128'h0, 0, 0, 1);
    vecs[1]  = v(1, 1, 4'hF, 32'h11111111, 0, 0, 128'h00000000_00000000_00000000_11111111, 1, 0, 1);
    vecs[2]  = v(1, 1, 4'hF, 32'h22222222, 0, 0, 128'h00000000_00000000_22222222_11111111, 2, 0, 1);
    vecs[3]  = v(1, 1, 4'hF, 32'h33333333, 0, 0, 128'h00000000_33333333_22222222_11111111, 3, 0, 1);
    vecs[4]  = v(1, 1, 4'hF, 32'h44444444, 0, 0, 128'h44444444_33333333_22222222_11111111, 0, 1, 0);
    vecs[5]  = v(1, 1, 4'hF, 32'h55555555, 0, 0, 128'h44444444_33333333_22222222_11111111, 0, 1, 0);
    vecs[6]  = v(1, 0, 4'hF, 32'h66666666, 1, 0, 128'h44444444_33333333_22222222_11111111, 0, 1, 0);
    vecs[7]  = v(1, 1, 4'hF, 32'hDEADBEEF, 0, 1, 128'h44444444_33333333_22222222_DEADBEEF, 1, 0, 1);
    vecs[8]  = v(1, 1, 4'hF, 32'hFFFFFFFF, 0, 0, 128'h44444444_33333333_FFFFFFFF_DEADBEEF, 2, 0, 1);
    vecs[9]  = v(1, 1, 4'hF, 32'hFFFFFFFF, 0, 0, 128'h44444444_FFFFFFFF_FFFFFFFF_DEADBEEF, 3, 0, 1);
    vecs[10] = v(1, 1, 4'hF, 32'hFFFFFFFF, 0, 0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_DEADBEEF, 0, 1, 0);
    vecs[11] = v(1, 0, 4'hF, 32'h00000000, 0, 1, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_DEADBEEF, 0, 0, 1);
    vecs[12] = v(1, 1, 4'h0, 32'h12345678, 0, 0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_DEADBEEF, 1, 0, 1);
    vecs[13] = v(1, 1, 4'h5, 32'hAABBCCDD, 0, 0, 128'hFFFFFFFF_FFFFFFFF_FFBBFFDD_DEADBEEF, 2, 0, 1);
    vecs[14] = v(1, 1, 4'hF, 32'h00000000, 1, 0, 128'hFFFFFFFF_FFFFFFFF_FFBBFFDD_DEADBEEF, 0, 0, 1);
    vecs[15] = v(0, 1, 4'hF, 32'h77777777, 1, 1, 128'h0, 0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].load, vecs[i].be, vecs[i].d, vecs[i].flush, vecs[i].lr);
      check($sformatf("vec%0d.data", i),  Data_Out, vecs[i].exp_data);
      check($sformatf("vec%0d.idx", i),   LW'(Word_Idx), LW'(vecs[i].exp_idx));
      check($sformatf("vec%0d.valid", i), LW'(Line_Valid), LW'(vecs[i].exp_valid));
      check($sformatf("vec%0d.rdy", i),   LW'(In_Ready), LW'(vecs[i].exp_rdy));
    end

    // Full line of all-ones, then a single-byte first word of the next line.
    for (int i = 0; i < NW; i++) drive(1, 1, 4'hF, 32'hFFFFFFFF, 0, 0);
    check("ones.valid", LW'(Line_Valid), LW'(1));
    drive(1, 1, 4'h1, 32'h000000AB, 0, 1);
    check("partial.word0", LW'(Data_Out[31:0]), LW'(32'hFFFFFFAB));
    check("partial.idx", LW'(Word_Idx), LW'(1));
    check_model("partial");

    // Stall while full: Load and Flush must not disturb the held line.
    for (int i = 0; i < NW - 1; i++) drive(1, 1, 4'hF, 32'h0000_0000 + i, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 4'hF, 32'hCAFE0000 + i, i[0], 0);
      check($sformatf("stall%0d.rdy", i), LW'(In_Ready), LW'(0));
      check_model($sformatf("stall%0d", i));
    end
    drive(1, 1, 4'hF, 32'hDEADBEEF, 0, 1);
    check("handoff.word0", LW'(Data_Out[31:0]), LW'(32'hDEADBEEF));
    check("handoff.valid", LW'(Line_Valid), LW'(0));

    // Reset in the middle of a line.
    drive(1, 1, 4'hF, 32'h0BADF00D, 0, 0);
    check("midreset.pre_idx", LW'(Word_Idx), LW'(2));
    drive(0, 1, 4'hF, 32'h12121212, 0, 0);
    check("midreset.data", Data_Out, LW'(0));
    check_model("midreset");

    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(63) != 0), ($urandom_range(3) != 0), 4'($urandom), $urandom,
            ($urandom_range(15) == 0), $urandom_range(1) == 1);
      check_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
